// File: rtl/key_search_pkg.sv
// Shared types and constants for the RC4 key search controller.
// The FSM state and the software-visible status codes are kept as separate encodings.
package key_search_pkg;

  localparam int KEY_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_ENG,
    ST_LAUNCH,
    ST_WAIT,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_TIMEOUT,
    ST_ABORTED
  } state_t;

  typedef enum logic [2:0] {
    STATUS_IDLE      = 3'd0,
    STATUS_RUNNING   = 3'd1,
    STATUS_FOUND     = 3'd2,
    STATUS_EXHAUSTED = 3'd3,
    STATUS_TIMEOUT   = 3'd4,
    STATUS_ABORTED   = 3'd5
  } status_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: flags the cycle in which d is high after being low on the previous clock.
module edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/key_search_ctrl.sv
// Steps the arcfour engine through an inclusive key range until a key decrypts,
// the range runs out, an attempt times out, or software aborts the search.
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int KEY_W          = KEY_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_first,
  input  logic [KEY_W-1:0] key_last,
  output logic             eng_reset,
  output logic             eng_start,
  output logic [KEY_W-1:0] eng_key,
  input  logic             eng_finished,
  input  logic             eng_success,
  output logic             busy,
  output logic [2:0]       status,
  output logic [KEY_W-1:0] found_key,
  output logic [KEY_W:0]   attempts
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  status_t            status_q;
  logic [KEY_W-1:0]   key_last_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               fin_rise;

  // Only a fresh 0->1 transition counts, so a finished level held over from the
  // previous attempt cannot be mistaken for a result of the current key.
  edge_detector u_fin_edge (
    .clk   (clk),
    .reset (reset),
    .d     (eng_finished),
    .rise  (fin_rise)
  );

  assign status = status_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      status_q   <= STATUS_IDLE;
      busy       <= 1'b0;
      eng_reset  <= 1'b0;
      eng_start  <= 1'b0;
      eng_key    <= '0;
      found_key  <= '0;
      attempts   <= '0;
      key_last_q <= '0;
      tmo_cnt    <= '0;
    end else begin
      eng_reset <= 1'b0;
      eng_start <= 1'b0;

      unique case (state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT, ST_ABORTED: begin
          if (go && !abort) begin
            key_last_q <= key_last;
            attempts   <= '0;
            found_key  <= '0;
            if (key_first > key_last) begin
              state    <= ST_EXHAUSTED;
              status_q <= STATUS_EXHAUSTED;
              busy     <= 1'b0;
            end else begin
              eng_key   <= key_first;
              eng_reset <= 1'b1;
              state     <= ST_RESET_ENG;
              status_q  <= STATUS_RUNNING;
              busy      <= 1'b1;
            end
          end
        end

        ST_RESET_ENG: begin
          if (abort) begin
            eng_reset <= 1'b1;
            state     <= ST_ABORTED;
            status_q  <= STATUS_ABORTED;
            busy      <= 1'b0;
          end else begin
            eng_start <= 1'b1;
            attempts  <= attempts + 1'b1;
            tmo_cnt   <= TMO_W'(TIMEOUT_CYCLES);
            state     <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          if (abort) begin
            eng_reset <= 1'b1;
            state     <= ST_ABORTED;
            status_q  <= STATUS_ABORTED;
            busy      <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            eng_reset <= 1'b1;
            state     <= ST_ABORTED;
            status_q  <= STATUS_ABORTED;
            busy      <= 1'b0;
          end else if (fin_rise) begin
            if (eng_success) begin
              found_key <= eng_key;
              state     <= ST_FOUND;
              status_q  <= STATUS_FOUND;
              busy      <= 1'b0;
            end else if (eng_key == key_last_q) begin
              state    <= ST_EXHAUSTED;
              status_q <= STATUS_EXHAUSTED;
              busy     <= 1'b0;
            end else begin
              eng_key   <= eng_key + 1'b1;
              eng_reset <= 1'b1;
              state     <= ST_RESET_ENG;
            end
          end else begin
            // Counter was loaded with TIMEOUT_CYCLES at launch; hitting zero
            // here gives up after exactly that many cycles of waiting.
            tmo_cnt <= tmo_cnt - 1'b1;
            if (tmo_cnt <= TMO_W'(1)) begin
              state    <= ST_TIMEOUT;
              status_q <= STATUS_TIMEOUT;
              busy     <= 1'b0;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          status_q <= STATUS_IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Scoreboard bench for key_search_ctrl: a behavioural engine model, a range-level
// outcome model feeding a queue, and a monitor that checks each completed search.
`timescale 1ns/1ps
module tb_key_search_ctrl;

  localparam int KEY_W = 24;
  localparam int TMO   = 100;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [KEY_W:0]   cnt_t;

  typedef struct {
    logic [2:0] st;
    key_t       found;
    cnt_t       att;
    key_t       first;
    key_t       last_key;
    int         done_cyc;
    int         starts;
    int         resets;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, go, abort;
  key_t       key_first, key_last;
  logic       eng_reset, eng_start;
  key_t       eng_key;
  logic       eng_finished, eng_success;
  logic       busy;
  logic [2:0] status;
  key_t       found_key;
  cnt_t       attempts;

  key_search_ctrl #(.KEY_W(KEY_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .abort        (abort),
    .key_first    (key_first),
    .key_last     (key_last),
    .eng_reset    (eng_reset),
    .eng_start    (eng_start),
    .eng_key      (eng_key),
    .eng_finished (eng_finished),
    .eng_success  (eng_success),
    .busy         (busy),
    .status       (status),
    .found_key    (found_key),
    .attempts     (attempts)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: finishes eng_lat cycles after a start, succeeds only on eng_target.
  key_t eng_target;
  logic eng_has_target, eng_never, eng_run;
  int   eng_lat, eng_rem;

  initial begin
    eng_finished = 1'b0;
    eng_success  = 1'b0;
    eng_run      = 1'b0;
    eng_rem      = 0;
    forever begin
      @(negedge clk);
      if (reset || eng_reset) begin
        eng_finished = 1'b0;
        eng_success  = 1'b0;
        eng_run      = 1'b0;
      end else if (eng_start) begin
        eng_finished = 1'b0;
        eng_run      = !eng_never;
        eng_rem      = eng_lat;
      end else if (eng_run) begin
        eng_rem--;
        if (eng_rem == 0) begin
          eng_run      = 1'b0;
          eng_finished = 1'b1;
          eng_success  = eng_has_target && (eng_key == eng_target);
        end
      end
    end
  end

  // Outcome of a whole search from the range rules, with go seen in cycle n_cyc.
  function automatic exp_t model(input key_t first, input key_t last, input logic has_t,
                                 input key_t target, input logic never, input int lat,
                                 input int ab_k, input int ab_off, input int n_cyc);
    exp_t e;
    longint n, hit, natural_n;
    e.first = first; e.found = '0; e.last_key = first;
    if (first > last) begin
      e.st = 3'd3; e.att = '0; e.done_cyc = n_cyc + 1; e.starts = 0; e.resets = 0;
      return e;
    end
    if (never) begin
      e.st = 3'd4; e.att = cnt_t'(1); e.done_cyc = n_cyc + 2 + TMO + 1; e.starts = 1; e.resets = 1;
      return e;
    end
    n = longint'(last) - longint'(first) + 1;
    hit = (has_t && target >= first && target <= last) ? longint'(target) - longint'(first) + 1 : 0;
    natural_n = (hit != 0) ? hit : n;
    if (ab_k != 0 && longint'(ab_k) <= natural_n) begin
      e.st = 3'd5; e.att = cnt_t'(ab_k); e.last_key = first + key_t'(ab_k - 1);
      e.done_cyc = n_cyc + 2 + (ab_k - 1) * (lat + 2) + ab_off + 1;
      e.starts = ab_k; e.resets = ab_k + 1;
    end else if (hit != 0) begin
      e.st = 3'd2; e.att = cnt_t'(hit); e.found = target; e.last_key = target;
      e.done_cyc = n_cyc + int'(hit) * (lat + 2) + 1;
      e.starts = int'(hit); e.resets = int'(hit);
    end else begin
      e.st = 3'd3; e.att = cnt_t'(n); e.last_key = last;
      e.done_cyc = n_cyc + int'(n) * (lat + 2) + 1;
      e.starts = int'(n); e.resets = int'(n);
    end
    return e;
  endfunction

  // Monitor: counts engine pulses, checks each launched key, pops on completion.
  int   m_starts, m_resets;
  key_t m_last_key;
  logic busy_prev, go_prev;
  exp_t me;

  initial begin
    m_starts = 0; m_resets = 0; m_last_key = '0; busy_prev = 1'b0; go_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_starts = 0; m_resets = 0; busy_prev = 1'b0; go_prev = 1'b0;
      end else begin
        check("busy_vs_running", longint'(busy), longint'(status == 3'd1));
        if (eng_reset) m_resets++;
        if (eng_start) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL stray_start: eng_start with no search pending (cycle %0d)", cyc);
          end else begin
            check("start_key", longint'(eng_key), longint'(key_t'(sb_q[0].first + key_t'(m_starts))));
          end
          m_last_key = eng_key;
          m_starts++;
        end
        if (status >= 3'd2 && (busy_prev || go_prev)) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: status=%0d with no search pending", status);
          end else begin
            me = sb_q.pop_front();
            check("status", longint'(status), longint'(me.st));
            check("attempts", longint'(attempts), longint'(me.att));
            check("done_cycle", longint'(cyc), longint'(me.done_cyc));
            check("start_pulses", longint'(m_starts), longint'(me.starts));
            check("reset_pulses", longint'(m_resets), longint'(me.resets));
            if (me.starts > 0) check("last_key", longint'(m_last_key), longint'(me.last_key));
            if (me.st == 3'd2) check("found_key", longint'(found_key), longint'(me.found));
          end
          m_starts = 0; m_resets = 0;
        end
        busy_prev = busy;
        go_prev   = go;
      end
    end
  end

  task automatic run_search(input key_t first, input key_t last, input logic has_t,
                            input key_t target, input logic never, input int lat,
                            input int ab_k, input int ab_off);
    exp_t e;
    int   n, ab_cyc, budget;
    eng_has_target = has_t; eng_target = target; eng_never = never; eng_lat = lat;
    @(posedge clk); #1;
    n = cyc;
    e = model(first, last, has_t, target, never, lat, ab_k, ab_off, n);
    sb_q.push_back(e);
    key_first = first; key_last = last; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    if (ab_k != 0) begin
      ab_cyc = n + 2 + (ab_k - 1) * (lat + 2) + ab_off;
      while (cyc < ab_cyc) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    budget = e.done_cyc - cyc + 20;
    while (sb_q.size() != 0 && budget > 0) begin @(posedge clk); #1; budget--; end
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL search_timeout: no completion by cycle %0d (expected %0d)", cyc, e.done_cyc);
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_status"},    longint'(status),    0);
    check({tag, "_busy"},      longint'(busy),      0);
    check({tag, "_eng_reset"}, longint'(eng_reset), 0);
    check({tag, "_eng_start"}, longint'(eng_start), 0);
    check({tag, "_eng_key"},   longint'(eng_key),   0);
    check({tag, "_found_key"}, longint'(found_key), 0);
    check({tag, "_attempts"},  longint'(attempts),  0);
  endtask

  key_t r_first, r_last, r_target;
  int   r_len, r_lat, r_abk, r_off;
  logic r_ht;
  exp_t r_e;

  initial begin
    reset = 1'b1; go = 1'b0; abort = 1'b0; key_first = '0; key_last = '0;
    eng_target = '0; eng_has_target = 1'b0; eng_never = 1'b0; eng_lat = 4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("por");

    run_search(24'h000000, 24'h000003, 1'b1, 24'h000002, 1'b0, 4, 0, 0);
    run_search(24'h000010, 24'h000012, 1'b0, 24'h000000, 1'b0, 3, 0, 0);
    run_search(24'h000005, 24'h000004, 1'b1, 24'h000005, 1'b0, 3, 0, 0);
    run_search(24'h000007, 24'h000009, 1'b0, 24'h000000, 1'b1, 3, 0, 0);
    run_search(24'h000020, 24'h000025, 1'b0, 24'h000000, 1'b0, 6, 2, 3);
    run_search(24'h000020, 24'h000022, 1'b1, 24'h000021, 1'b0, 5, 0, 0);
    run_search(24'hFFFFFE, 24'hFFFFFF, 1'b0, 24'h000000, 1'b0, 3, 0, 0);
    run_search(24'hFFFFFD, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b0, 2, 0, 0);

    for (int i = 0; i < 14; i++) begin
      r_first = key_t'($urandom);
      if (i % 4 == 3) r_first = 24'hFFFFFF - key_t'($urandom_range(0, 4));
      r_len = $urandom_range(0, 5);
      if (r_len == 0) begin
        if (r_first == '0) r_first = key_t'(1);
        r_last = r_first - 1'b1;
      end else if (r_first > 24'hFFFFFF - key_t'(r_len - 1)) begin
        r_last = 24'hFFFFFF;
      end else begin
        r_last = r_first + key_t'(r_len - 1);
      end
      r_ht     = 1'($urandom_range(0, 1));
      r_target = r_first + key_t'($urandom_range(0, r_len + 1));
      r_lat    = $urandom_range(2, 10);
      r_abk    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      r_off    = $urandom_range(1, r_lat - 1);
      run_search(r_first, r_last, r_ht, r_target, 1'b0, r_lat, r_abk, r_off);
    end

    // Asynchronous reset in the middle of a waiting attempt.
    eng_never = 1'b1; eng_has_target = 1'b0; eng_lat = 3;
    @(posedge clk); #1;
    r_e = model(24'h000040, 24'h000050, 1'b0, '0, 1'b1, 3, 0, 0, cyc);
    sb_q.push_back(r_e);
    key_first = 24'h000040; key_last = 24'h000050; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check_reset_values("async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_search(24'h000100, 24'h000102, 1'b1, 24'h000101, 1'b0, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
